// File: rtl/serial_addsub_unit.sv
// serial_addsub_unit
//   Word-framed serial adder/subtractor. Two WIDTH-bit operands are loaded on
//   an accepted start and processed LSB-first, one bit per clock, through a
//   single full-adder slice and a carry flip-flop. Each sum bit is streamed
//   out serially; the assembled result, carry-out and signed-overflow flag
//   are then presented with a one-cycle done pulse.
//
//   State | Meaning
//   ------+--------------------------------------------------------------
//   IDLE  | waiting for start; result/cout/overflow hold the last answer
//   SHIFT | one full-adder step per clock, WIDTH steps total
//   DONE  | result valid, done pulses, start ignored; always back to IDLE
//
// Ports
//   clk        system clock, rising edge
//   reset      asynchronous active-low reset
//   start      request, sampled only in IDLE
//   sub        0 = a+b, 1 = a-b (sampled with start)
//   a, b       operands (sampled with start)
//   busy       high while in SHIFT
//   sum_bit    registered serial sum bit, LSB first
//   sum_valid  qualifies sum_bit
//   result     assembled sum/difference, held until next accepted start
//   cout       final carry (not-borrow for subtract)
//   overflow   signed overflow: carry into MSB xor carry out of MSB
//   done       one-cycle pulse when result/cout/overflow are valid
module serial_addsub_unit #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             sum_bit,
  output logic             sum_valid,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             overflow,
  output logic             done
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic             carry;
  logic [CNT_W-1:0] cnt;

  logic bit_s;
  logic bit_c;
  logic last_bit;
  logic accept;

  // Single full-adder slice on the current LSBs.
  assign bit_s    = op_a[0] ^ op_b[0] ^ carry;
  assign bit_c    = (op_a[0] & op_b[0]) | (op_a[0] & carry) | (op_b[0] & carry);
  assign last_bit = (cnt == CNT_W'(WIDTH - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) begin
          accept    = 1'b1;
          state_nxt = S_SHIFT;
        end
      end
      S_SHIFT: begin
        if (last_bit) begin
          state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        state_nxt = S_IDLE;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  // busy/done are registered copies of the next state so every output
  // comes straight from a flop.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      busy <= (state_nxt == S_SHIFT);
      done <= (state_nxt == S_DONE);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      op_a      <= '0;
      op_b      <= '0;
      carry     <= 1'b0;
      cnt       <= '0;
      result    <= '0;
      cout      <= 1'b0;
      overflow  <= 1'b0;
      sum_bit   <= 1'b0;
      sum_valid <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            // Subtract as a + ~b + 1: the +1 enters through the carry.
            op_a   <= a;
            op_b   <= sub ? ~b : b;
            carry  <= sub;
            cnt    <= '0;
            result <= '0;
          end
        end
        S_SHIFT: begin
          op_a      <= op_a >> 1;
          op_b      <= op_b >> 1;
          carry     <= bit_c;
          result    <= {bit_s, result[WIDTH-1:1]};
          sum_bit   <= bit_s;
          sum_valid <= 1'b1;
          cnt       <= cnt + CNT_W'(1);
          if (last_bit) begin
            cout     <= bit_c;
            overflow <= carry ^ bit_c;
          end
        end
        S_DONE: begin
          sum_valid <= 1'b0;
        end
        default: begin
          sum_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_addsub_unit.sv
module tb_serial_addsub_unit;

  localparam int WIDTH = 8;

  logic             clk;
  logic             reset;
  logic             start;
  logic             sub;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             sum_bit;
  logic             sum_valid;
  logic [WIDTH-1:0] result;
  logic             cout;
  logic             overflow;
  logic             done;

  int n_checks = 0;
  int n_fail   = 0;

  serial_addsub_unit #(.WIDTH(WIDTH)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .sub      (sub),
    .a        (a),
    .b        (b),
    .busy     (busy),
    .sum_bit  (sum_bit),
    .sum_valid(sum_valid),
    .result   (result),
    .cout     (cout),
    .overflow (overflow),
    .done     (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             sub;
    logic [WIDTH-1:0] res;
    logic             cout;
    logic             ovf;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Runs one operation from IDLE and checks stream, timing and flags.
  task automatic run_op(input string tag, input logic [WIDTH-1:0] ta, input logic [WIDTH-1:0] tb_v,
                        input logic ts, input logic [WIDTH-1:0] e_res, input logic e_cout,
                        input logic e_ovf);
    logic [WIDTH-1:0] bits;
    int               n_valid;
    int               done_idx;
    int               done_cnt;
    bits     = '0;
    n_valid  = 0;
    done_idx = -1;
    done_cnt = 0;
    @(negedge clk);
    a = ta; b = tb_v; sub = ts; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    a = ~ta; b = ~tb_v; sub = ~ts;
    chk({tag, " busy after accept"}, 64'(busy), 64'd1);
    chk({tag, " sum_valid after accept"}, 64'(sum_valid), 64'd0);
    for (int i = 1; i <= WIDTH + 4; i++) begin
      @(negedge clk);
      if (sum_valid) begin
        if (n_valid < WIDTH) bits[n_valid] = sum_bit;
        n_valid++;
      end
      if (done) begin
        done_cnt++;
        if (done_idx < 0) begin
          done_idx = i;
          chk({tag, " result"}, 64'(result), 64'(e_res));
          chk({tag, " cout"}, 64'(cout), 64'(e_cout));
          chk({tag, " overflow"}, 64'(overflow), 64'(e_ovf));
          chk({tag, " busy at done"}, 64'(busy), 64'd0);
        end
      end
    end
    chk({tag, " done index"}, 64'(done_idx), 64'(WIDTH));
    chk({tag, " done pulses"}, 64'(done_cnt), 64'd1);
    chk({tag, " sum_valid count"}, 64'(n_valid), 64'(WIDTH));
    chk({tag, " sum_bit stream"}, 64'(bits), 64'(e_res));
    chk({tag, " result held"}, 64'(result), 64'(e_res));
    chk({tag, " idle busy"}, 64'(busy), 64'd0);
  endtask

  initial begin
    logic [WIDTH-1:0] held_res;
    int               done_idx;
    int               reacc_idx;
    int               to;

    vecs[0] = '{a: 8'h5A, b: 8'h33, sub: 1'b0, res: 8'h8D, cout: 1'b0, ovf: 1'b1};
    vecs[1] = '{a: 8'hFF, b: 8'h01, sub: 1'b0, res: 8'h00, cout: 1'b1, ovf: 1'b0};
    vecs[2] = '{a: 8'h05, b: 8'h07, sub: 1'b1, res: 8'hFE, cout: 1'b0, ovf: 1'b0};
    vecs[3] = '{a: 8'h80, b: 8'h01, sub: 1'b1, res: 8'h7F, cout: 1'b1, ovf: 1'b1};
    vecs[4] = '{a: 8'h33, b: 8'h33, sub: 1'b1, res: 8'h00, cout: 1'b1, ovf: 1'b0};
    vecs[5] = '{a: 8'h7F, b: 8'h01, sub: 1'b0, res: 8'h80, cout: 1'b0, ovf: 1'b1};
    vecs[6] = '{a: 8'h00, b: 8'h00, sub: 1'b1, res: 8'h00, cout: 1'b1, ovf: 1'b0};
    vecs[7] = '{a: 8'h80, b: 8'h80, sub: 1'b0, res: 8'h00, cout: 1'b1, ovf: 1'b1};

    reset = 1'b0; start = 1'b0; sub = 1'b0; a = '0; b = '0;
    #3;
    chk("reset busy", 64'(busy), 64'd0);
    chk("reset outputs", 64'({sum_bit, sum_valid, result, cout, overflow, done}), 64'd0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("post-reset idle", 64'({busy, done, sum_valid}), 64'd0);

    foreach (vecs[i]) begin
      run_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].sub,
             vecs[i].res, vecs[i].cout, vecs[i].ovf);
    end

    // Handshake: start held high, operands changed after acceptance.
    @(negedge clk);
    a = 8'h01; b = 8'h02; sub = 1'b0; start = 1'b1;
    @(negedge clk);
    chk("hs busy", 64'(busy), 64'd1);
    a = 8'hAA; b = 8'h55;
    done_idx = -1; reacc_idx = -1; held_res = '0;
    for (int i = 1; i <= WIDTH + 4; i++) begin
      @(negedge clk);
      if (done && done_idx < 0) begin
        done_idx = i;
        held_res = result;
      end
      if (busy && i > WIDTH && reacc_idx < 0) begin
        reacc_idx = i;
        start = 1'b0;
      end
    end
    chk("hs done index", 64'(done_idx), 64'(WIDTH));
    chk("hs first result", 64'(held_res), 64'h03);
    // Accept edge of the second op is WIDTH+2 edges after the first.
    chk("hs reaccept edge", 64'(reacc_idx), 64'(WIDTH + 2));
    to = 0;
    while (!done && to < 4 * WIDTH) begin
      @(negedge clk);
      to++;
    end
    chk("hs second done seen", 64'(done), 64'd1);
    chk("hs second result", 64'(result), 64'hFF);
    @(negedge clk);

    // Abort mid-shift with an asynchronous reset.
    @(negedge clk);
    a = 8'h0F; b = 8'hF0; sub = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    chk("abort mid busy", 64'(busy), 64'd1);
    #2 reset = 1'b0;
    #1;
    chk("abort outputs", 64'({busy, sum_bit, sum_valid, result, cout, overflow, done}), 64'd0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("abort idle", 64'({busy, done, sum_valid}), 64'd0);
    run_op("after abort", 8'h10, 8'h20, 1'b0, 8'h30, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, got no end expected end");
    $fatal(1, "timeout");
  end

endmodule
